// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible panel model: 80-byte DDRAM, address counter, display flags, busy timing.
// Define LCD_TIMING_CHECK_EN to add the LCD_E high-width check and TIMING_ERR output.
module lcd_hd44780_responder #(
    parameter int unsigned T42_CYCLES   = 2100,
    parameter int unsigned T1640_CYCLES = 82000,
    parameter int unsigned E_MIN_CYCLES = 13
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_E,
    input  logic [7:0] LCD_DB_I,
    output logic [7:0] LCD_DB_O,
    output logic       LCD_DB_OE,
    input  logic [6:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic [6:0] AC,
    output logic       BUSY,
    output logic       DISP_ON,
    output logic       CURSOR_ON,
    output logic       BLINK_ON,
    output logic       CMD_DROP
`ifdef LCD_TIMING_CHECK_EN
    ,
    output logic       TIMING_ERR
`endif
);

    localparam int unsigned T_MAX = (T1640_CYCLES > T42_CYCLES) ? T1640_CYCLES : T42_CYCLES;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    logic [7:0]       mem [80];
    logic             e_q;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic             drop_q, drop_d;
    logic             sweep_q, sweep_d;
    logic [6:0]       sweep_idx_q, sweep_idx_d;
    logic [7:0]       rd_data_q;
    logic             fall;
    logic             mem_we;
    logic [6:0]       mem_waddr;
    logic [7:0]       mem_wdata;
    logic [7:0]       rd_byte;

    function automatic logic addr_valid(input logic [6:0] a);
        return a[5:0] < 6'd40;
    endfunction

    function automatic logic [6:0] phys_idx(input logic [6:0] a);
        return {1'b0, a[5:0]} + (a[6] ? 7'd40 : 7'd0);
    endfunction

    // Wraps between the two visible lines; the invalid gaps count through naturally.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else return a + 7'd1;
        end else begin
            if (a == 7'h40) return 7'h27;
            else if (a == 7'h00) return 7'h67;
            else return a - 7'd1;
        end
    endfunction

    assign fall    = e_q & ~LCD_E;
    assign rd_byte = addr_valid(ac_q) ? mem[phys_idx(ac_q)] : 8'h00;

    always_comb begin
        LCD_DB_OE = RST & LCD_E & LCD_RW;
        LCD_DB_O  = 8'h00;
        if (LCD_DB_OE) LCD_DB_O = LCD_RS ? rd_byte : {busy_q, ac_q};
    end

    always_comb begin
        ac_d        = ac_q;
        id_d        = id_q;
        busy_d      = busy_q;
        busy_cnt_d  = busy_cnt_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        drop_d      = drop_q;
        sweep_d     = sweep_q;
        sweep_idx_d = sweep_idx_q;
        mem_we      = 1'b0;
        mem_waddr   = phys_idx(ac_q);
        mem_wdata   = LCD_DB_I;

        if (busy_q) begin
            if (busy_cnt_q == '0) busy_d = 1'b0;
            else busy_cnt_d = busy_cnt_q - 1'b1;
        end

        if (fall) begin
            if (LCD_RW) begin
                if (LCD_RS) ac_d = ac_step(ac_q, id_q);
            end else if (busy_q) begin
                drop_d = 1'b1;
            end else begin
                busy_d     = 1'b1;
                busy_cnt_d = CNT_W'(T42_CYCLES - 1);
                if (LCD_RS) begin
                    mem_we = addr_valid(ac_q);
                    ac_d   = ac_step(ac_q, id_q);
                end else begin
                    unique casez (LCD_DB_I)
                        8'b1???????: ac_d = LCD_DB_I[6:0];
                        8'b01??????: ;
                        8'b001?????: ;
                        8'b0001????: if (!LCD_DB_I[3]) ac_d = ac_step(ac_q, LCD_DB_I[2]);
                        8'b00001???: begin
                            disp_d  = LCD_DB_I[2];
                            cur_d   = LCD_DB_I[1];
                            blink_d = LCD_DB_I[0];
                        end
                        8'b000001??: id_d = LCD_DB_I[1];
                        8'b0000001?: begin
                            ac_d       = 7'h00;
                            busy_cnt_d = CNT_W'(T1640_CYCLES - 1);
                        end
                        8'b00000001: begin
                            sweep_d     = 1'b1;
                            sweep_idx_d = 7'd0;
                            busy_cnt_d  = CNT_W'(T1640_CYCLES - 1);
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Sweep runs only while busy, so it never contends with a bus write.
        if (sweep_q) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_idx_q;
            mem_wdata = 8'h20;
            if (sweep_idx_q == 7'd79) begin
                sweep_d = 1'b0;
                ac_d    = 7'h00;
                id_d    = 1'b1;
            end else begin
                sweep_idx_d = sweep_idx_q + 7'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_q         <= 1'b0;
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            busy_q      <= 1'b0;
            busy_cnt_q  <= '0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            drop_q      <= 1'b0;
            sweep_q     <= 1'b0;
            sweep_idx_q <= 7'd0;
            rd_data_q   <= 8'h00;
        end else begin
            e_q         <= LCD_E;
            ac_q        <= ac_d;
            id_q        <= id_d;
            busy_q      <= busy_d;
            busy_cnt_q  <= busy_cnt_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            drop_q      <= drop_d;
            sweep_q     <= sweep_d;
            sweep_idx_q <= sweep_idx_d;
            rd_data_q   <= (RD_ADDR < 7'd80) ? mem[RD_ADDR] : 8'h00;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign RD_DATA   = rd_data_q;
    assign AC        = ac_q;
    assign BUSY      = busy_q;
    assign DISP_ON   = disp_q;
    assign CURSOR_ON = cur_q;
    assign BLINK_ON  = blink_q;
    assign CMD_DROP  = drop_q;

`ifdef LCD_TIMING_CHECK_EN
    logic [15:0] e_cnt_q;
    logic        terr_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_cnt_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            if (LCD_E) begin
                if (e_cnt_q != 16'hffff) e_cnt_q <= e_cnt_q + 16'd1;
            end else begin
                e_cnt_q <= '0;
            end
            if (fall && (32'(e_cnt_q) < E_MIN_CYCLES)) terr_q <= 1'b1;
        end
    end

    assign TIMING_ERR = terr_q;
`endif

endmodule
